sd_ddr_dat_tx: RTL and testbench

SD-card DDR50 write-data transmitter for the 4-bit DAT bus. It takes one block of bytes over a valid/ready stream and frames it as preamble, start bit, payload, per-lane/per-edge CRC16 and end bit. It drives the rising-half (D0) and falling-half (D1) inputs of four ODDRX1F output cells, plus the DAT tristate enable. It is the transmit counterpart of the IDDRX1F-based DAT receive path.

---
 rtl/sd_ddr_pkg.sv | 18 +
 rtl/sd_crc16_serial.sv | 25 ++
 rtl/sd_ddr_dat_tx.sv | 161 ++++++++++++++++
 tb/tb_sd_ddr_dat_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sd_ddr_pkg.sv
// Shared types and constants for the SD DDR50 DAT transmit path.
package sd_ddr_pkg;

    // Frame phases of one DAT write block
    typedef enum logic [2:0] {
        IDLE,
        PRE,
        STRT,
        DATA,
        CRC,
        ENDB
    } tx_state_t;

    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam int          SD_LANES    = 4;
    localparam logic [3:0]  IDLE_NIBBLE = 4'hF;

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), init 0, one bit per enabled cycle.
module sd_crc16_serial
    import sd_ddr_pkg::*;
(
    input  logic        sclk,
    input  logic        rstb,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;

    assign fb = din ^ crc[15];

    // Shift in one payload bit MSB-first; clear takes priority over update
    always_ff @(posedge sclk) begin
        if (!rstb || clr)
            crc <= '0;
        else if (en)
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end

endmodule

// File: rtl/sd_ddr_dat_tx.sv
// SD DDR50 write-data transmitter for the 4-bit DAT bus, feeding ODDRX1F D0/D1.
// Frame: preamble, start bit, payload, per-lane/per-edge CRC16, end bit.
// Optional: define SD_DDR_TX_CRC_EN to include the CRC phase; without it
// DATA goes straight to the end bit (bring-up / loopback builds).
module sd_ddr_dat_tx
    import sd_ddr_pkg::*;
#(
    parameter int BLOCK_BYTES = 512
) (
    input  logic                SCLK,
    input  logic                RST,
    input  logic                START,
    input  logic [7:0]          DIN,
    input  logic                DIN_VALID,
    output logic                DIN_READY,
    output logic [SD_LANES-1:0] D0,
    output logic [SD_LANES-1:0] D1,
    output logic                OE,
    output logic                BUSY,
    output logic                DONE,
    output logic                UNDERRUN
);

    localparam int             CW   = $clog2(BLOCK_BYTES + 1);
    localparam logic [CW-1:0]  LAST = CW'(BLOCK_BYTES);

    tx_state_t             state, state_nx;
    logic [CW-1:0]         byte_cnt, byte_cnt_nx;
    logic [SD_LANES-1:0]   d0_nx, d1_nx;
    logic                  oe_nx, done_nx, unr_nx;
    logic                  start_acc;
    logic [7:0]            tx_byte;

    // A missing byte still occupies its slot and is sent (and CRC'd) as zero
    assign tx_byte   = DIN_VALID ? DIN : 8'h00;
    assign start_acc = (state == IDLE) && START;
    assign DIN_READY = (state == STRT) || ((state == DATA) && (byte_cnt != LAST));
    assign BUSY      = (state != IDLE);

`ifdef SD_DDR_TX_CRC_EN
    logic [3:0]                 crc_cnt, crc_cnt_nx;
    logic [SD_LANES-1:0][15:0]  crc_a, crc_b;

    // One generator per lane per clock half; D0 half carries the high nibble
    for (genvar i = 0; i < SD_LANES; i++) begin : g_lane
        sd_crc16_serial u_crc_a (
            .sclk(SCLK), .rstb(RST), .clr(start_acc), .en(DIN_READY),
            .din(tx_byte[4+i]), .crc(crc_a[i])
        );
        sd_crc16_serial u_crc_b (
            .sclk(SCLK), .rstb(RST), .clr(start_acc), .en(DIN_READY),
            .din(tx_byte[i]), .crc(crc_b[i])
        );
    end
`endif

    // Next state and next registered pin values
    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        d0_nx       = IDLE_NIBBLE;
        d1_nx       = IDLE_NIBBLE;
        oe_nx       = 1'b1;
        done_nx     = 1'b0;
        unr_nx      = UNDERRUN;
`ifdef SD_DDR_TX_CRC_EN
        crc_cnt_nx  = crc_cnt;
`endif
        if (DIN_READY && !DIN_VALID)
            unr_nx = 1'b1;
        case (state)
            IDLE: begin
                oe_nx = START;
                if (START) begin
                    state_nx = PRE;
                    unr_nx   = 1'b0;
                end
            end
            PRE: begin
                state_nx = STRT;
                d0_nx    = '0;
                d1_nx    = '0;
            end
            STRT: begin
                state_nx    = DATA;
                byte_cnt_nx = CW'(1);
                d0_nx       = tx_byte[7:4];
                d1_nx       = tx_byte[3:0];
            end
            DATA: begin
                if (byte_cnt == LAST) begin
`ifdef SD_DDR_TX_CRC_EN
                    // Generators already hold the full block: last update was the previous edge
                    state_nx   = CRC;
                    crc_cnt_nx = '0;
                    for (int i = 0; i < SD_LANES; i++) begin
                        d0_nx[i] = crc_a[i][15];
                        d1_nx[i] = crc_b[i][15];
                    end
`else
                    state_nx = ENDB;
`endif
                end else begin
                    byte_cnt_nx = byte_cnt + CW'(1);
                    d0_nx       = tx_byte[7:4];
                    d1_nx       = tx_byte[3:0];
                end
            end
`ifdef SD_DDR_TX_CRC_EN
            CRC: begin
                if (crc_cnt == 4'd15) begin
                    state_nx = ENDB;
                end else begin
                    crc_cnt_nx = crc_cnt + 4'd1;
                    for (int i = 0; i < SD_LANES; i++) begin
                        d0_nx[i] = crc_a[i][4'd14 - crc_cnt];
                        d1_nx[i] = crc_b[i][4'd14 - crc_cnt];
                    end
                end
            end
`endif
            ENDB: begin
                state_nx = IDLE;
                oe_nx    = 1'b0;
                done_nx  = 1'b1;
            end
            default: begin
                state_nx = IDLE;
                oe_nx    = 1'b0;
            end
        endcase
    end

    // State, counters and registered pins; reset abandons any block in flight
    always_ff @(posedge SCLK) begin
        if (!RST) begin
            state    <= IDLE;
            byte_cnt <= '0;
            D0       <= IDLE_NIBBLE;
            D1       <= IDLE_NIBBLE;
            OE       <= 1'b0;
            DONE     <= 1'b0;
            UNDERRUN <= 1'b0;
`ifdef SD_DDR_TX_CRC_EN
            crc_cnt  <= '0;
`endif
        end else begin
            state    <= state_nx;
            byte_cnt <= byte_cnt_nx;
            D0       <= d0_nx;
            D1       <= d1_nx;
            OE       <= oe_nx;
            DONE     <= done_nx;
            UNDERRUN <= unr_nx;
`ifdef SD_DDR_TX_CRC_EN
            crc_cnt  <= crc_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_sd_ddr_dat_tx.sv
// Directed bench for sd_ddr_dat_tx with a 4-byte block.
module tb_sd_ddr_dat_tx;

    localparam int N = 4;
`ifdef SD_DDR_TX_CRC_EN
    localparam int NCRC = 16;
`else
    localparam int NCRC = 0;
`endif
    localparam int END_CYC  = 3 + N + NCRC;
    localparam int DONE_CYC = END_CYC + 1;
    localparam int MAXC     = DONE_CYC + 2;

    logic       SCLK, RST, START, DIN_VALID;
    logic [7:0] DIN;
    logic       DIN_READY, OE, BUSY, DONE, UNDERRUN;
    logic [3:0] D0, D1;

    sd_ddr_dat_tx #(.BLOCK_BYTES(N)) dut (
        .SCLK(SCLK), .RST(RST), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .D0(D0), .D1(D1), .OE(OE), .BUSY(BUSY),
        .DONE(DONE), .UNDERRUN(UNDERRUN)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    int checks   = 0;
    int failures = 0;

    logic [3:0] od0  [0:MAXC];
    logic [3:0] od1  [0:MAXC];
    logic       ooe  [0:MAXC];
    logic       odn  [0:MAXC];
    logic       obsy [0:MAXC];
    logic       ordy [0:MAXC];
    logic       ounr [0:MAXC];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

`ifdef SD_DDR_TX_CRC_EN
    // CRC as remainder of M(x)*x^16 mod G(x), by long division
    function automatic logic [15:0] crc_ref(input logic [3:0] bits);
        logic [19:0] r;
        r = {bits, 16'h0000};
        for (int j = 19; j >= 16; j--)
            if (r[j]) r[j -: 17] = r[j -: 17] ^ 17'h11021;
        return r[15:0];
    endfunction
`endif

    // Send START at the next edge (E0) and record cycles 1..MAXC
    task automatic run_block(input logic [31:0] blk, input logic [3:0] vmask,
                             input int ign_cyc, input int rst_cyc);
        START = 1'b1;
        @(posedge SCLK); #1;
        START = 1'b0;
        for (int c = 1; c <= MAXC; c++) begin
            od0[c] = D0; od1[c] = D1; ooe[c] = OE; odn[c] = DONE;
            obsy[c] = BUSY; ordy[c] = DIN_READY; ounr[c] = UNDERRUN;
            if (c >= 2 && c <= N + 1) begin
                DIN       = blk[31 - 8*(c-2) -: 8];
                DIN_VALID = vmask[c-2];
            end else begin
                DIN       = 8'h00;
                DIN_VALID = 1'b0;
            end
            START = (c == ign_cyc);
            RST   = !(c == rst_cyc);
            @(posedge SCLK); #1;
        end
        START = 1'b0; RST = 1'b1; DIN_VALID = 1'b0;
    endtask

    task automatic check_block(input string nm, input logic [31:0] blk, input logic [3:0] vmask);
        logic [7:0]  bs [0:N-1];
        logic [3:0]  sa, sb, e0, e1;
        logic [15:0] ca [0:3];
        logic [15:0] cb [0:3];
        for (int k = 0; k < N; k++)
            bs[k] = vmask[k] ? blk[31 - 8*k -: 8] : 8'h00;
        chk({nm, " pre_oe"}, 32'(ooe[1]), 32'd1);
        chk({nm, " pre_d"}, 32'({od0[1], od1[1]}), 32'hFF);
        chk({nm, " strt_d"}, 32'({od0[2], od1[2]}), 32'h00);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s pay%0d", nm, k), 32'({od0[3+k], od1[3+k]}), 32'(bs[k]));
            chk($sformatf("%s rdy%0d", nm, 2+k), 32'(ordy[2+k]), 32'd1);
        end
        chk({nm, " rdy_off"}, 32'(ordy[2+N]), 32'd0);
`ifdef SD_DDR_TX_CRC_EN
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) begin
                sa[3-k] = bs[k][4+i];
                sb[3-k] = bs[k][i];
            end
            ca[i] = crc_ref(sa);
            cb[i] = crc_ref(sb);
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                e0[i] = ca[i][15-k];
                e1[i] = cb[i][15-k];
            end
            chk($sformatf("%s crc%0d", nm, k), 32'({od0[3+N+k], od1[3+N+k]}), 32'({e0, e1}));
        end
`endif
        chk({nm, " end_d"}, 32'({od0[END_CYC], od1[END_CYC]}), 32'hFF);
        chk({nm, " end_oe"}, 32'(ooe[END_CYC]), 32'd1);
        chk({nm, " done_oe"}, 32'(ooe[DONE_CYC]), 32'd0);
        for (int c = 1; c <= MAXC; c++) begin
            chk($sformatf("%s done@%0d", nm, c), 32'(odn[c]), 32'(c == DONE_CYC));
            chk($sformatf("%s busy@%0d", nm, c), 32'(obsy[c]), 32'(c <= END_CYC));
        end
    endtask

    initial begin
        RST = 1'b0; START = 1'b0; DIN = 8'h00; DIN_VALID = 1'b0;
        repeat (3) @(posedge SCLK);
        #1;
        chk("rst_d", 32'({D0, D1}), 32'hFF);
        chk("rst_oe", 32'(OE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_unr", 32'(UNDERRUN), 32'd0);
        chk("rst_rdy", 32'(DIN_READY), 32'd0);
        RST = 1'b1;
        @(posedge SCLK); #1;

        // Normal block with a stray START mid-block that must be ignored
        run_block(32'hA53CFF00, 4'hF, (NCRC != 0) ? 10 : 4, 0);
        check_block("blkA", 32'hA53CFF00, 4'hF);
        for (int c = 1; c <= MAXC; c++)
            chk($sformatf("blkA unr@%0d", c), 32'(ounr[c]), 32'd0);

        // All-zero payload: CRC is zero on every stream
        run_block(32'h00000000, 4'hF, 0, 0);
        check_block("zero", 32'h00000000, 4'hF);

        // Third slot empty (DIN=0x77 but not valid)
        run_block(32'h11227744, 4'b1011, 0, 0);
        check_block("unr", 32'h11227744, 4'b1011);
        for (int c = 1; c <= MAXC; c++)
            chk($sformatf("unr unr@%0d", c), 32'(ounr[c]), 32'(c >= 5));

        // Reset in the fourth payload cycle (cycle 6)
        run_block(32'hA53CFF00, 4'hF, 0, 6);
        chk("rstm unr_clr", 32'(ounr[1]), 32'd0);
        chk("rstm pay0", 32'({od0[3], od1[3]}), 32'hA5);
        chk("rstm d", 32'({od0[7], od1[7]}), 32'hFF);
        chk("rstm oe", 32'(ooe[7]), 32'd0);
        chk("rstm rdy", 32'(ordy[7]), 32'd0);
        for (int c = 7; c <= MAXC; c++) begin
            chk($sformatf("rstm busy@%0d", c), 32'(obsy[c]), 32'd0);
            chk($sformatf("rstm done@%0d", c), 32'(odn[c]), 32'd0);
        end

        // Fresh block after the abort
        run_block(32'hA53CFF00, 4'hF, 0, 0);
        check_block("post", 32'hA53CFF00, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
